// File: rtl/mem_fifo_ctrl.sv
// FIFO controller for an external 1R1W masked SRAM macro.
// A 2-entry output buffer hides the macro's 1-cycle read latency.
module mem_fifo_ctrl #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH      = 64,
  parameter int MASK_GRAN  = 8,
  localparam int MASK_WIDTH = WIDTH / MASK_GRAN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [WIDTH-1:0]        enq_data,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [WIDTH-1:0]        deq_data,
  output logic [ADDR_WIDTH+1:0]   count,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  output logic                    mem_r_en,
  input  logic [WIDTH-1:0]        mem_r_data,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic                    mem_w_en,
  output logic [WIDTH-1:0]        mem_w_data,
  output logic [MASK_WIDTH-1:0]   mem_w_mask
);

  localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_mem_cnt;
  logic                  r_inflight;
  logic [WIDTH-1:0]      r_ob0;
  logic [WIDTH-1:0]      r_ob1;
  logic [1:0]            r_ob_cnt;

  logic                  w_enq_fire;
  logic                  w_deq_fire;
  logic                  w_rd_fire;
  logic [1:0]            w_ob_left;
  logic [1:0]            w_ob_cnt_nxt;
  logic [WIDTH-1:0]      w_ob0_nxt;
  logic [WIDTH-1:0]      w_ob1_nxt;

  assign enq_ready  = (r_mem_cnt < L_DEPTH);
  assign deq_valid  = (r_ob_cnt != 2'd0);
  assign w_enq_fire = rst_n & enq_valid & enq_ready;
  assign w_deq_fire = rst_n & deq_valid & deq_ready;
  assign w_ob_left  = r_ob_cnt - {1'b0, w_deq_fire};

  // Issue a read only if the buffer can absorb it after this cycle's pop.
  assign w_rd_fire = rst_n & (r_mem_cnt != '0) &
                     ((w_ob_left + {1'b0, r_inflight}) < 2'd2);

  assign mem_w_en   = w_enq_fire;
  assign mem_w_addr = r_wptr;
  assign mem_w_data = enq_data;
  assign mem_w_mask = {MASK_WIDTH{w_enq_fire}};
  assign mem_r_en   = w_rd_fire;
  assign mem_r_addr = r_rptr;
  assign deq_data   = r_ob0;

  assign count = {1'b0, r_mem_cnt}
               + {{ADDR_WIDTH{1'b0}}, r_ob_cnt}
               + {{(ADDR_WIDTH+1){1'b0}}, r_inflight};

  // Pop the head first, then land returning read data at the new tail.
  always_comb begin
    w_ob0_nxt    = r_ob0;
    w_ob1_nxt    = r_ob1;
    w_ob_cnt_nxt = w_ob_left + {1'b0, r_inflight};
    if (w_deq_fire) begin
      w_ob0_nxt = r_ob1;
    end
    if (r_inflight) begin
      if (w_ob_left == 2'd0) begin
        w_ob0_nxt = mem_r_data;
      end else begin
        w_ob1_nxt = mem_r_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_ob0      <= '0;
      r_ob1      <= '0;
      r_ob_cnt   <= '0;
    end else begin
      if (w_enq_fire) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_fire) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_mem_cnt  <= r_mem_cnt
                  + (ADDR_WIDTH+1)'(w_enq_fire)
                  - (ADDR_WIDTH+1)'(w_rd_fire);
      r_inflight <= w_rd_fire;
      r_ob0      <= w_ob0_nxt;
      r_ob1      <= w_ob1_nxt;
      r_ob_cnt   <= w_ob_cnt_nxt;
    end
  end

endmodule
